// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, one write port and two registered read ports.
// Define REG_FILE_BYPASS_EN to forward same-edge write data onto a read of the same index.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic [DATA_W-1:0]        out1,
  output logic [DATA_W-1:0]        out2,
  output logic                     rd_valid,
  output logic [(1<<ADDR_W)-1:0]   dirty
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  // One-hot write select; index 0 is never selected, so r0 stays zero and never goes dirty.
  always_comb begin
    wr_sel = '0;
    if (wr_en && (wr_addr != '0))
      wr_sel[wr_addr] = 1'b1;
  end

  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
    rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_sel[rd_addr1])
      rd_data1 = wr_data;
    if (wr_sel[rd_addr2])
      rd_data2 = wr_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_sel[i])
          mem[i] <= wr_data;
    end
  end

  // Read outputs hold their value whenever no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1     <= '0;
      out2     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        out1 <= rd_data1;
        out2 <= rd_data2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dirty <= '0;
    else
      dirty <= dirty | wr_sel;
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file; directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic [15:0] out1;
  logic [15:0] out2;
  logic        rd_valid;
  logic [7:0]  dirty;

  int checks;
  int failures;

  logic [15:0] m_mem [8];
  logic [7:0]  m_dirty;
  logic [15:0] m_out1;
  logic [15:0] m_out2;
  logic        m_valid;

  reg_file #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .out1(out1), .out2(out2), .rd_valid(rd_valid), .dirty(dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read sampled on this edge must return, given the write also on this edge.
  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (wr_addr == a)) return wr_data;
`endif
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    m_dirty = 8'h00;
    m_out1  = 16'h0000;
    m_out2  = 16'h0000;
    m_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (rd_en) begin
      m_out1  = m_read(rd_addr1);
      m_out2  = m_read(rd_addr2);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr_en && (wr_addr != 3'd0)) begin
      m_mem[wr_addr]   = wr_data;
      m_dirty[wr_addr] = 1'b1;
    end
  endtask

  // Advance one rising edge, update the model, and land 1ns after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_en = 0; rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    checks++;
    if (out1 !== 16'h0 || out2 !== 16'h0 || rd_valid !== 1'b0 || dirty !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_initial: got out1=%h out2=%h valid=%b dirty=%h required all zero",
               out1, out2, rd_valid, dirty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1; wr_addr = 3'd4; wr_data = 16'h1234;
    step();
    wr_en = 0; rd_en = 1; rd_addr1 = 3'd4; rd_addr2 = 3'd4;
    step();
    checks++;
    if (out1 !== 16'h1234 || dirty !== 8'h10 || rd_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_read: got out1=%h dirty=%h valid=%b required 1234 10 1",
               out1, dirty, rd_valid);
    end
    rd_en = 0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out1 !== 16'h0 || out2 !== 16'h0 || rd_valid !== 1'b0 || dirty !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_async: got out1=%h out2=%h valid=%b dirty=%h required all zero",
               out1, out2, rd_valid, dirty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 1; rd_addr1 = 3'd4; rd_addr2 = 3'd4;
    step();
    checks++;
    if (out1 !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_cleared_reg: got %h required 0000", out1);
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 3'd1; wr_data = 16'd10;
    step();
    wr_addr = 3'd2; wr_data = 16'd15;
    step();
    wr_en = 0; rd_en = 1; rd_addr1 = 3'd1; rd_addr2 = 3'd2;
    step();
    checks++;
    if (out1 !== 16'd10 || out2 !== 16'd15 || rd_valid !== 1'b1 || dirty !== 8'h06) begin
      failures++;
      $display("[TB] FAIL write_read: got out1=%0d out2=%0d valid=%b dirty=%h required 10 15 1 06",
               out1, out2, rd_valid, dirty);
    end
    idle_inputs();
  endtask

  task automatic test_r0();
    wr_en = 1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    step();
    wr_en = 0; rd_en = 1; rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    step();
    checks++;
    if (out1 !== 16'h0 || out2 !== 16'h0 || dirty[0] !== 1'b0 || dirty !== 8'h06) begin
      failures++;
      $display("[TB] FAIL r0_zero: got out1=%h out2=%h dirty=%h required 0000 0000 06",
               out1, out2, dirty);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
`ifdef REG_FILE_BYPASS_EN
    exp = 16'h00AA;
`else
    exp = 16'h0005;
`endif
    wr_en = 1; wr_addr = 3'd3; wr_data = 16'h0005;
    step();
    wr_data = 16'h00AA; rd_en = 1; rd_addr1 = 3'd3; rd_addr2 = 3'd1;
    step();
    checks++;
    if (out1 !== exp || out2 !== 16'd10) begin
      failures++;
      $display("[TB] FAIL same_edge_rw: got out1=%h out2=%h required %h 000a", out1, out2, exp);
    end
    wr_en = 0; rd_addr2 = 3'd3;
    step();
    checks++;
    if (out1 !== 16'h00AA || out2 !== 16'h00AA) begin
      failures++;
      $display("[TB] FAIL write_visible_later: got out1=%h out2=%h required 00aa 00aa", out1, out2);
    end
    idle_inputs();
  endtask

  task automatic test_hold_valid();
    logic       pattern [4];
    logic [7:0] dirty_before;
    pattern = '{1'b1, 1'b1, 1'b0, 1'b1};
    dirty_before = dirty;
    for (int k = 0; k < 4; k++) begin
      rd_en    = pattern[k];
      rd_addr1 = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : (k == 2) ? 3'd3 : 3'd2;
      rd_addr2 = (k == 0) ? 3'd2 : (k == 1) ? 3'd1 : (k == 2) ? 3'd3 : 3'd3;
      step();
      checks++;
      if (rd_valid !== pattern[k] || out1 !== m_out1 || out2 !== m_out2) begin
        failures++;
        $display("[TB] FAIL hold_valid[%0d]: got valid=%b out1=%h out2=%h required %b %h %h",
                 k, rd_valid, out1, out2, pattern[k], m_out1, m_out2);
      end
    end
    checks++;
    if (dirty !== dirty_before) begin
      failures++;
      $display("[TB] FAIL dirty_stable: got %h required %h", dirty, dirty_before);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    rd_en = 1; rd_addr1 = 3'd1; rd_addr2 = 3'd2;
    step();
    checks++;
    if (rd_valid !== 1'b1 || out1 !== 16'd10) begin
      failures++;
      $display("[TB] FAIL mid_read_setup: got valid=%b out1=%h required 1 000a", rd_valid, out1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rd_valid !== 1'b0 || out1 !== 16'h0 || out2 !== 16'h0 || dirty !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_read_reset: got valid=%b out1=%h out2=%h dirty=%h required zero",
               rd_valid, out1, out2, dirty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 1; rd_addr1 = 3'd1; rd_addr2 = 3'd1;
    step();
    checks++;
    if (rd_valid !== 1'b1 || out1 !== 16'h0 || out2 !== 16'h0) begin
      failures++;
      $display("[TB] FAIL first_read_after_reset: got valid=%b out1=%h out2=%h required 1 0 0",
               rd_valid, out1, out2);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      rd_en    = ($urandom_range(0, 3) != 0);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      step();
      checks++;
      if (out1 !== m_out1 || out2 !== m_out2 || rd_valid !== m_valid || dirty !== m_dirty) begin
        failures++;
        $display("[TB] FAIL random[%0d]: got %h %h %b %h required %h %h %b %h", n,
                 out1, out2, rd_valid, dirty, m_out1, m_out2, m_valid, m_dirty);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_hold_valid();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
